// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_CH registered-read FIFOs into one valid/ready stream.
// Each grant lasts up to BURST words; every output word carries its source channel.
module fifo_drain_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 4,
   parameter int BURST      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            ch_empty,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
   output logic [NUM_CH-1:0]            ch_rd_en,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(NUM_CH)-1:0]    out_ch,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy
);

   localparam int CW = $clog2(NUM_CH);
   localparam int BW = $clog2(BURST) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_CAPT,
      S_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         g_q, g_d;
   logic [CW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CW-1:0]         out_ch_q, out_ch_d;
   logic                  out_valid_q, out_valid_d;

   logic                  found;
   logic [CW-1:0]         pick;
   int                    idx;
   logic [BW-1:0]         beat_nxt;
   logic [CW-1:0]         g_nxt;

   // Descending walk so the channel closest to rr_ptr is assigned last and wins.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_CH;
         if (!ch_empty[idx]) begin
            found = 1'b1;
            pick  = CW'(idx);
         end
      end
   end

   always_comb begin
      beat_nxt = beat_q + BW'(1);
      g_nxt    = (g_q == CW'(NUM_CH - 1)) ? '0 : g_q + CW'(1);
   end

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      rr_ptr_d    = rr_ptr_q;
      beat_d      = beat_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               g_d     = pick;
               beat_d  = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
            out_data_d  = ch_dout[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
            out_ch_d    = g_q;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               beat_d      = beat_nxt;
               if (beat_nxt < BW'(BURST) && !ch_empty[g_q]) begin
                  state_d = S_READ;
               end else begin
                  rr_ptr_d = g_nxt;
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         g_q         <= '0;
         rr_ptr_q    <= '0;
         beat_q      <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_q      <= beat_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      ch_rd_en = '0;
      if (state_q == S_READ) ch_rd_en[g_q] = 1'b1;
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter with behavioural registered-read FIFOs.
module tb_fifo_drain_arbiter;

   localparam int DW = 32;
   localparam int NC = 4;
   localparam int BU = 4;

   typedef struct packed {
      logic [1:0]    ch;
      logic [DW-1:0] d;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NC-1:0]    ch_empty;
   logic [NC*DW-1:0] ch_dout;
   logic [NC-1:0]    ch_rd_en;
   logic [DW-1:0]    out_data;
   logic [1:0]       out_ch;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   logic [DW-1:0]    mem [NC][16];
   int               wr_ptr [NC];
   int               rd_ptr [NC];

   exp_t             sb [$];
   int               total = 0;
   int               bad = 0;

   always #5 clk = ~clk;

   fifo_drain_arbiter #(
      .DATA_WIDTH(DW),
      .NUM_CH    (NC),
      .BURST     (BU)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_empty (ch_empty),
      .ch_dout  (ch_dout),
      .ch_rd_en (ch_rd_en),
      .out_data (out_data),
      .out_ch   (out_ch),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy)
   );

   // Source FIFOs: dout updates on the edge that samples rd_en.
   always_comb begin
      for (int i = 0; i < NC; i++) ch_empty[i] = (rd_ptr[i] == wr_ptr[i]);
   end

   always @(posedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (rst) begin
            rd_ptr[i]         <= 0;
            ch_dout[i*DW +: DW] <= '0;
         end else if (ch_rd_en[i]) begin
            ch_dout[i*DW +: DW] <= mem[i][rd_ptr[i] % 16];
            rd_ptr[i]           <= rd_ptr[i] + 1;
         end
      end
   end

   task automatic fill(input int ch, input logic [DW-1:0] d);
      mem[ch][wr_ptr[ch] % 16] = d;
      wr_ptr[ch]++;
   endtask

   task automatic expect_word(input int ch, input logic [DW-1:0] d);
      exp_t e;
      e.ch = 2'(ch);
      e.d  = d;
      sb.push_back(e);
   endtask

   // One cycle: drive out_ready at the falling edge, then check what the
   // next rising edge will see (rd_en legality and any handshake).
   task automatic cyc(input logic rdy = 1'b1);
      exp_t e;
      @(negedge clk);
      out_ready = rdy;
      if (ch_rd_en != '0) begin
         total++;
         if ((ch_rd_en & ch_empty) != '0 || !$onehot(ch_rd_en)) begin
            bad++;
            $display("FAIL rd_en_legal: rd_en=%b empty=%b", ch_rd_en, ch_empty);
         end
      end
      if (out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got ch=%0d data=%h, none expected",
                     out_ch, out_data);
         end else begin
            e = sb.pop_front();
            if (out_ch !== e.ch || out_data !== e.d) begin
               bad++;
               $display("FAIL sb_word: got ch=%0d data=%h, want ch=%0d data=%h",
                        out_ch, out_data, e.ch, e.d);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < NC; i++) wr_ptr[i] = 0;
      sb.delete();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         cyc(1'b1);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d words left, want 0", sb.size());
      end
      sb.delete();
      cyc(1'b1);
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || ch_rd_en !== '0) begin
         bad++;
         $display("FAIL reset_ctrl: valid=%b busy=%b rd_en=%b, want 0 0 0",
                  out_valid, busy, ch_rd_en);
      end
      total++;
      if (out_data !== '0 || out_ch !== '0) begin
         bad++;
         $display("FAIL reset_data: data=%h ch=%0d, want 0 0", out_data, out_ch);
      end
      total++;
      if (dut.rr_ptr_q !== 2'd0) begin
         bad++;
         $display("FAIL reset_rr: rr_ptr=%0d, want 0", dut.rr_ptr_q);
      end
   endtask

   task automatic test_single();
      do_reset();
      fill(2, 32'hA5A5_0002);
      expect_word(2, 32'hA5A5_0002);
      cyc();
      total++;
      if (ch_rd_en !== 4'b0100 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_rd: rd_en=%b busy=%b, want 0100 1", ch_rd_en, busy);
      end
      cyc();
      total++;
      if (ch_rd_en !== 4'b0000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_capt: rd_en=%b valid=%b, want 0000 0",
                  ch_rd_en, out_valid);
      end
      cyc();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || out_ch !== 2'd2) begin
         bad++;
         $display("FAIL single_out: valid=%b data=%h ch=%0d, want 1 a5a50002 2",
                  out_valid, out_data, out_ch);
      end
      cyc();
      total++;
      if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd3) begin
         bad++;
         $display("FAIL single_end: busy=%b rr_ptr=%0d, want 0 3",
                  busy, dut.rr_ptr_q);
      end
   endtask

   task automatic test_burst();
      do_reset();
      for (int k = 0; k < 6; k++) fill(0, DW'(k));
      fill(1, 32'h100);
      for (int k = 0; k < 4; k++) expect_word(0, DW'(k));
      expect_word(1, 32'h100);
      expect_word(0, 32'd4);
      expect_word(0, 32'd5);
      drain(100);
   endtask

   task automatic test_fairness();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NC; i++) begin
            fill(i, DW'(16 * i + r));
            expect_word(i, DW'(16 * i + r));
         end
         drain(100);
         total++;
         if (dut.rr_ptr_q !== 2'd0) begin
            bad++;
            $display("FAIL rr_wrap: rr_ptr=%0d, want 0", dut.rr_ptr_q);
         end
      end
   endtask

   task automatic test_back_pressure();
      int n;
      logic [DW-1:0] hd;
      logic [1:0] hc;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         fill(1, DW'(32'h1000 + k));
         expect_word(1, DW'(32'h1000 + k));
      end
      n = 0;
      while (sb.size() > 2 && n < 50) begin
         cyc(1'b1);
         n++;
      end
      n = 0;
      cyc(1'b0);
      while (!out_valid && n < 50) begin
         cyc(1'b0);
         n++;
      end
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_wait: valid=%b, want 1", out_valid);
      end
      hd = out_data;
      hc = out_ch;
      repeat (10) begin
         cyc(1'b0);
         total++;
         if (out_valid !== 1'b1 || out_data !== hd || out_ch !== hc ||
             ch_rd_en !== '0) begin
            bad++;
            $display("FAIL bp_stall: valid=%b data=%h ch=%0d rd_en=%b, want 1 %h %0d 0000",
                     out_valid, out_data, out_ch, ch_rd_en, hd, hc);
         end
      end
      drain(50);
   endtask

   task automatic test_reset_mid();
      int n;
      int pulses;
      do_reset();
      fill(1, 32'hB1);
      expect_word(1, 32'hB1);
      drain(50);
      for (int k = 0; k < 3; k++) begin
         fill(3, DW'(32'h300 + k));
         expect_word(3, DW'(32'h300 + k));
      end
      n = 0;
      pulses = 0;
      while (pulses < 2 && n < 50) begin
         cyc(1'b1);
         if (ch_rd_en[3]) pulses++;
         n++;
      end
      total++;
      if (pulses != 2) begin
         bad++;
         $display("FAIL rm_reads: rd pulses=%0d, want 2", pulses);
      end
      cyc(1'b1);
      rst = 1'b1;
      sb.delete();
      for (int i = 0; i < NC; i++) wr_ptr[i] = 0;
      cyc(1'b1);
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || ch_rd_en !== '0 ||
          busy !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
         bad++;
         $display("FAIL rm_state: valid=%b data=%h rd_en=%b busy=%b rr=%0d, want 0 0 0 0 0",
                  out_valid, out_data, ch_rd_en, busy, dut.rr_ptr_q);
      end
      rst = 1'b0;
      for (int i = 0; i < NC; i++) begin
         fill(i, DW'(32'h400 + i));
         expect_word(i, DW'(32'h400 + i));
      end
      drain(100);
   endtask

   task automatic test_idle();
      do_reset();
      repeat (20) begin
         cyc(1'b1);
         total++;
         if (ch_rd_en !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle: rd_en=%b valid=%b busy=%b, want 0000 0 0",
                     ch_rd_en, out_valid, busy);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      test_reset();
      test_single();
      test_burst();
      test_fairness();
      test_back_pressure();
      test_reset_mid();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
